mem_stage_sram_responder: RTL and testbench

- Memory-stage responder for the load/store requests the decode stage raises (mem_read for LDR, mem_write for STR).
- Services each 32-bit word access as two 16-bit half-word accesses on an external asynchronous SRAM.
- Drives a ready handshake that the hazard/freeze logic uses to stall the pipeline while an access is in progress.
- Sits between the EX/MEM pipeline register and the SRAM pins.

---
 rtl/mem_stage_sram_responder.sv | 121 ++++++++++++
 tb/tb_mem_stage_sram_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage_sram_responder                                                   |
// | Services 32-bit LDR/STR word accesses as two 16-bit async SRAM halves.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_stage_sram_responder #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned HALF_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] C_LAST = 4'(HALF_CYCLES - 1);

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic               r_is_wr;
  logic [SRAM_AW-2:0] r_word;
  logic [15:0]        r_wdata_hi;

  logic [31:0]        w_eff;
  logic               w_last;
  logic               w_req;
  logic               w_unused_bits;

  assign w_eff  = address - BASE_ADDR;
  assign w_last = (r_cnt == C_LAST);
  assign w_req  = rd_en | wr_en;

  // Byte offset and bits beyond the SRAM span are deliberately dropped.
  assign w_unused_bits = &{1'b0, w_eff[31:SRAM_AW+1], w_eff[1:0]};

  assign ready = (r_state == S_DONE) || ((r_state == S_IDLE) && !w_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_is_wr     <= 1'b0;
      r_word      <= '0;
      r_wdata_hi  <= 16'd0;
      read_data   <= 32'd0;
      sram_addr   <= '0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            // Write wins over a simultaneous read.
            r_is_wr     <= wr_en;
            r_word      <= w_eff[SRAM_AW:2];
            r_wdata_hi  <= write_data[31:16];
            sram_addr   <= {w_eff[SRAM_AW:2], 1'b0};
            sram_dq_out <= write_data[15:0];
            sram_dq_oe  <= wr_en;
            sram_we_n   <= ~wr_en;
            r_cnt       <= 4'd0;
            r_state     <= S_LO;
          end
        end
        S_LO: begin
          if (w_last) begin
            if (!r_is_wr) begin
              read_data[15:0] <= sram_dq_in;
            end
            r_cnt       <= 4'd0;
            sram_addr   <= {r_word, 1'b1};
            sram_dq_out <= r_wdata_hi;
            r_state     <= S_HI;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_HI: begin
          if (w_last) begin
            if (!r_is_wr) begin
              read_data[31:16] <= sram_dq_in;
            end
            r_cnt      <= 4'd0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_stage_sram_responder                                                |
// | Directed vector bench for the two-half SRAM load/store responder.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_stage_sram_responder;

  localparam int H0 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: default HALF_CYCLES = 2
  logic        rd0 = 1'b0, wr0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wd0 = 32'd0;
  logic [31:0] rdata0;
  logic        ready0, oe0, we_n0;
  logic [17:0] saddr0;
  logic [15:0] dqo0, dqi0;

  // Instance 1: HALF_CYCLES = 1
  logic        rd1 = 1'b0, wr1 = 1'b0;
  logic [31:0] addr1 = 32'd0, wd1 = 32'd0;
  logic [31:0] rdata1;
  logic        ready1, oe1, we_n1;
  logic [17:0] saddr1;
  logic [15:0] dqo1, dqi1;

  mem_stage_sram_responder #(.BASE_ADDR(1024), .HALF_CYCLES(2), .SRAM_AW(18)) u_dut0 (
    .clk(clk), .rst(rst), .rd_en(rd0), .wr_en(wr0), .address(addr0), .write_data(wd0),
    .read_data(rdata0), .ready(ready0), .sram_addr(saddr0), .sram_dq_out(dqo0),
    .sram_dq_in(dqi0), .sram_dq_oe(oe0), .sram_we_n(we_n0)
  );

  mem_stage_sram_responder #(.BASE_ADDR(1024), .HALF_CYCLES(1), .SRAM_AW(18)) u_dut1 (
    .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(addr1), .write_data(wd1),
    .read_data(rdata1), .ready(ready1), .sram_addr(saddr1), .sram_dq_out(dqo1),
    .sram_dq_in(dqi1), .sram_dq_oe(oe1), .sram_we_n(we_n1)
  );

  // Async SRAM model behind instance 0
  logic [15:0] mem0 [0:(1<<18)-1];
  always @(posedge clk) begin
    if (!we_n0 && oe0) mem0[saddr0] <= dqo0;
  end
  assign dqi0 = mem0[saddr0];

  // Fixed read-only contents behind instance 1
  assign dqi1 = (saddr1 == 18'd4) ? 16'h1357 : (saddr1 == 18'd5) ? 16'h2468 : 16'h0000;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [17:0] lo;
    logic [17:0] hi;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [0:8];

  // Called just after a negedge with instance 0 idle; returns just after a negedge.
  task automatic run_vec(input vec_t v);
    logic [15:0] half;
    rd0 = v.rd; wr0 = v.wr; addr0 = v.addr; wd0 = v.wd;
    #1;
    chk("req_ready", {31'd0, ready0}, 32'd0);
    @(posedge clk); #1;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = 32'hFFFF_0000; wd0 = 32'h0BAD_0BAD;
    for (int k = 0; k < 2*H0; k++) begin
      @(negedge clk);
      half = (k < H0) ? v.wd[15:0] : v.wd[31:16];
      chk("busy_ready", {31'd0, ready0}, 32'd0);
      chk("sram_addr", {14'd0, saddr0}, {14'd0, (k < H0) ? v.lo : v.hi});
      chk("we_n", {31'd0, we_n0}, {31'd0, ~v.wr});
      chk("dq_oe", {31'd0, oe0}, {31'd0, v.wr});
      if (v.wr) chk("dq_out", {16'd0, dqo0}, {16'd0, half});
    end
    @(negedge clk);
    chk("done_ready", {31'd0, ready0}, 32'd1);
    chk("done_we_n", {31'd0, we_n0}, 32'd1);
    chk("done_oe", {31'd0, oe0}, 32'd0);
    chk("read_data", rdata0, v.exp_rd);
    @(negedge clk);
    chk("idle_ready", {31'd0, ready0}, 32'd1);
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 18'd4,       18'd5,       32'h0000_0000};
    vt[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,        18'd4,       18'd5,       32'hDEADBEEF};
    vt[2] = '{1'b1, 1'b0, 32'd1035, 32'h0,        18'd4,       18'd5,       32'hDEADBEEF};
    vt[3] = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 18'd0,       18'd1,       32'hDEADBEEF};
    vt[4] = '{1'b1, 1'b0, 32'd1024, 32'h0,        18'd0,       18'd1,       32'h12345678};
    vt[5] = '{1'b0, 1'b1, 32'd5024, 32'hA5A50F0F, 18'd2000,    18'd2001,    32'h12345678};
    vt[6] = '{1'b1, 1'b0, 32'd5024, 32'h0,        18'd2000,    18'd2001,    32'hA5A50F0F};
    vt[7] = '{1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 18'h3FFFE,   18'h3FFFF,   32'hA5A50F0F};
    vt[8] = '{1'b1, 1'b0, 32'd1020, 32'h0,        18'h3FFFE,   18'h3FFFF,   32'hCAFEF00D};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_ready", {31'd0, ready0}, 32'd1);
      chk("rst_we_n", {31'd0, we_n0}, 32'd1);
      chk("rst_oe", {31'd0, oe0}, 32'd0);
      chk("rst_rdata", rdata0, 32'd0);
      chk("rst_saddr", {14'd0, saddr0}, 32'd0);
    end

    for (int i = 0; i < 9; i++) run_vec(vt[i]);

    // Reset during the high half of a store
    wr0 = 1'b1; addr0 = 32'd1040; wd0 = 32'h11112222;
    @(posedge clk); #1;
    wr0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("hi_saddr", {14'd0, saddr0}, 32'd9);
    chk("hi_we_n", {31'd0, we_n0}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'd0, ready0}, 32'd1);
    chk("abort_we_n", {31'd0, we_n0}, 32'd1);
    chk("abort_oe", {31'd0, oe0}, 32'd0);
    chk("abort_rdata", rdata0, 32'd0);

    // Back-to-back loads held through ready, HALF_CYCLES = 2
    rd0 = 1'b1; addr0 = 32'd1032;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk); else #1;
      chk("b2b_ready", {31'd0, ready0}, {31'd0, (i % 6) == 5});
      if ((i % 6) == 5) chk("b2b_rdata", rdata0, 32'hDEADBEEF);
    end
    rd0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_idle", {31'd0, ready0}, 32'd1);

    // Back-to-back loads, HALF_CYCLES = 1
    rd1 = 1'b1; addr1 = 32'd1032;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk); else #1;
      chk("h1_ready", {31'd0, ready1}, {31'd0, (i % 4) == 3});
      if ((i % 4) == 1) chk("h1_saddr_lo", {14'd0, saddr1}, 32'd4);
      if ((i % 4) == 2) chk("h1_saddr_hi", {14'd0, saddr1}, 32'd5);
      if ((i % 4) == 3) chk("h1_rdata", rdata1, 32'h24681357);
    end
    rd1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("h1_idle", {31'd0, ready1}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
